// File: rtl/tge_tx_packetizer_if.sv
// Fabric TX bus between the packetizer and the 10GbE core.
// The master drives framed words; the slave returns backpressure and overflow status.
interface tge_tx_packetizer_if;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_end_of_frame;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull;
  logic        tx_overflow;

  modport master (
    output tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
    input  tx_afull, tx_overflow
  );

  modport slave (
    input  tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
    output tx_afull, tx_overflow
  );
endinterface

// File: rtl/tge_tx_packetizer.sv
// Buffers a 64-bit sample stream in a show-ahead FIFO and frames it as
// fixed-length UDP payloads (header word + PAYLOAD_WORDS data words) for the 10GbE core.
module tge_tx_packetizer #(
  parameter int PAYLOAD_WORDS = 128,
  parameter int FIFO_AW       = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [63:0]                din,
  input  logic                       din_valid,
  input  logic [31:0]                dest_ip,
  input  logic [15:0]                dest_port,
  tge_tx_packetizer_if.master        tx,
  output logic [31:0]                pkt_count,
  output logic [31:0]                drop_count,
  output logic                       overflow_seen
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int FILL_W = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t              state_reg, state_next;
  logic [63:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg, wcnt_reg;
  logic [FILL_W-1:0]   fill_reg;
  logic [47:0]         seq_reg;
  logic                fifo_full, wr_en, rd_en, last_word, start_ok;

  assign fifo_full = (fill_reg == FILL_W'(DEPTH));
  assign wr_en     = din_valid && en && !fifo_full;
  assign rd_en     = (state_reg == PAYLOAD) && !tx.tx_afull;
  assign last_word = rd_en && (wcnt_reg == FIFO_AW'(PAYLOAD_WORDS - 1));
  assign start_ok  = en && (fill_reg >= FILL_W'(PAYLOAD_WORDS)) && !tx.tx_afull;

  // Head word is read combinationally so a pop and its data share the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = HEADER;
      HEADER:  state_next = PAYLOAD;
      PAYLOAD: if (last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid        = 1'b0;
    tx.tx_data         = '0;
    tx.tx_end_of_frame = 1'b0;
    case (state_reg)
      HEADER: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = {seq_reg, 16'(PAYLOAD_WORDS)};
      end
      PAYLOAD: begin
        if (!tx.tx_afull) begin
          tx.tx_valid        = 1'b1;
          tx.tx_data         = mem[rd_ptr_reg];
          tx.tx_end_of_frame = last_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fill_reg        <= '0;
      wcnt_reg        <= '0;
      seq_reg         <= '0;
      pkt_count       <= '0;
      drop_count      <= '0;
      overflow_seen   <= 1'b0;
      tx.tx_dest_ip   <= '0;
      tx.tx_dest_port <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   fill_reg <= fill_reg + FILL_W'(1);
        2'b01:   fill_reg <= fill_reg - FILL_W'(1);
        default: fill_reg <= fill_reg;
      endcase

      if (last_word) begin
        wcnt_reg  <= '0;
        seq_reg   <= seq_reg + 48'd1;
        pkt_count <= pkt_count + 32'd1;
      end else if (rd_en) begin
        wcnt_reg <= wcnt_reg + FIFO_AW'(1);
      end

      // A word offered while the FIFO is full is lost, even if a pop frees a slot this cycle.
      if (din_valid && en && fifo_full && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end

      if (tx.tx_overflow) begin
        overflow_seen <= 1'b1;
      end

      if ((state_reg == IDLE) && start_ok) begin
        tx.tx_dest_ip   <= dest_ip;
        tx.tx_dest_port <= dest_port;
      end
    end
  end

endmodule

// File: tb/tb_tge_tx_packetizer.sv
// Directed bench for tge_tx_packetizer with PAYLOAD_WORDS=4, FIFO_AW=3:
// framing, backpressure, FIFO overfill, destination latching, async reset and overflow flag.
module tb_tge_tx_packetizer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] din;
  logic        din_valid;
  logic [31:0] dest_ip;
  logic [15:0] dest_port;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic        overflow_seen;

  int n_cmp = 0;
  int n_err = 0;

  tge_tx_packetizer_if tx_if ();

  tge_tx_packetizer #(
    .PAYLOAD_WORDS (4),
    .FIFO_AW       (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .din           (din),
    .din_valid     (din_valid),
    .dest_ip       (dest_ip),
    .dest_port     (dest_port),
    .tx            (tx_if),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .overflow_seen (overflow_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then check the TX outputs for that cycle.
  task automatic step(input string tag, input logic dv, input logic [63:0] dd, input logic af,
                      input logic ev, input logic [63:0] ed, input logic ee);
    @(negedge clk);
    din_valid      = dv;
    din            = dd;
    tx_if.tx_afull = af;
    #1;
    chk({tag, "_valid"}, 64'(tx_if.tx_valid), 64'(ev));
    chk({tag, "_data"},  tx_if.tx_data, ed);
    chk({tag, "_eof"},   64'(tx_if.tx_end_of_frame), 64'(ee));
    $display("step %-12s dv=%0d din=%h afull=%0d -> valid=%0d data=%h eof=%0d",
             tag, dv, dd, af, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_end_of_frame);
  endtask

  initial begin
    rst               = 1'b0;
    en                = 1'b1;
    din               = '0;
    din_valid         = 1'b0;
    dest_ip           = 32'h0A00_0001;
    dest_port         = 16'h1234;
    tx_if.tx_afull    = 1'b0;
    tx_if.tx_overflow = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(tx_if.tx_valid), 64'd0);
    chk("rst_data", tx_if.tx_data, 64'd0);
    chk("rst_eof", 64'(tx_if.tx_end_of_frame), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_ovf", 64'(overflow_seen), 64'd0);
    chk("rst_ip", 64'(tx_if.tx_dest_ip), 64'd0);
    chk("rst_port", 64'(tx_if.tx_dest_port), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Frame 1: words 1..4, header seq 0
    step("f1_w1", 1, 64'd1, 0, 0, 64'd0, 0);
    step("f1_w2", 1, 64'd2, 0, 0, 64'd0, 0);
    step("f1_w3", 1, 64'd3, 0, 0, 64'd0, 0);
    step("f1_w4", 1, 64'd4, 0, 0, 64'd0, 0);
    step("f1_idle", 0, 64'd0, 0, 0, 64'd0, 0);
    step("f1_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0000_0004, 0);
    chk("f1_ip", 64'(tx_if.tx_dest_ip), 64'h0A00_0001);
    chk("f1_port", 64'(tx_if.tx_dest_port), 64'h1234);
    step("f1_p1", 0, 64'd0, 0, 1, 64'd1, 0);
    dest_ip = 32'h0A00_0002;
    step("f1_p2", 0, 64'd0, 0, 1, 64'd2, 0);
    step("f1_p3", 0, 64'd0, 0, 1, 64'd3, 0);
    step("f1_p4", 0, 64'd0, 0, 1, 64'd4, 1);

    // Frame 2: words 5..8, header seq 1, afull for 3 cycles after the 2nd payload word
    step("f2_w5", 1, 64'd5, 0, 0, 64'd0, 0);
    chk("f1_pkt", 64'(pkt_count), 64'd1);
    chk("f1_ip_hold", 64'(tx_if.tx_dest_ip), 64'h0A00_0001);
    step("f2_w6", 1, 64'd6, 0, 0, 64'd0, 0);
    step("f2_w7", 1, 64'd7, 0, 0, 64'd0, 0);
    step("f2_w8", 1, 64'd8, 0, 0, 64'd0, 0);
    step("f2_idle", 0, 64'd0, 0, 0, 64'd0, 0);
    step("f2_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0001_0004, 0);
    chk("f2_ip", 64'(tx_if.tx_dest_ip), 64'h0A00_0002);
    step("f2_p5", 0, 64'd0, 0, 1, 64'd5, 0);
    step("f2_p6", 0, 64'd0, 0, 1, 64'd6, 0);
    step("f2_af1", 0, 64'd0, 1, 0, 64'd0, 0);
    step("f2_af2", 0, 64'd0, 1, 0, 64'd0, 0);
    step("f2_af3", 0, 64'd0, 1, 0, 64'd0, 0);
    step("f2_p7", 0, 64'd0, 0, 1, 64'd7, 0);
    step("f2_p8", 0, 64'd0, 0, 1, 64'd8, 1);
    step("f2_end", 0, 64'd0, 0, 0, 64'd0, 0);
    chk("f2_pkt", 64'(pkt_count), 64'd2);

    // Overfill under backpressure: 10 writes into an 8-deep FIFO, 17 and 18 dropped
    step("of_w9", 1, 64'd9, 1, 0, 64'd0, 0);
    step("of_w10", 1, 64'd10, 1, 0, 64'd0, 0);
    step("of_w11", 1, 64'd11, 1, 0, 64'd0, 0);
    step("of_w12", 1, 64'd12, 1, 0, 64'd0, 0);
    step("of_w13", 1, 64'd13, 1, 0, 64'd0, 0);
    step("of_w14", 1, 64'd14, 1, 0, 64'd0, 0);
    step("of_w15", 1, 64'd15, 1, 0, 64'd0, 0);
    step("of_w16", 1, 64'd16, 1, 0, 64'd0, 0);
    step("of_w17", 1, 64'd17, 1, 0, 64'd0, 0);
    step("of_w18", 1, 64'd18, 1, 0, 64'd0, 0);
    step("of_rel", 0, 64'd0, 0, 0, 64'd0, 0);
    chk("of_drop", 64'(drop_count), 64'd2);
    step("f3_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0002_0004, 0);
    step("f3_p9", 0, 64'd0, 0, 1, 64'd9, 0);
    step("f3_p10", 0, 64'd0, 0, 1, 64'd10, 0);
    step("f3_p11", 0, 64'd0, 0, 1, 64'd11, 0);
    step("f3_p12", 0, 64'd0, 0, 1, 64'd12, 1);
    step("f3_gap", 0, 64'd0, 0, 0, 64'd0, 0);
    step("f4_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0003_0004, 0);
    step("f4_p13", 0, 64'd0, 0, 1, 64'd13, 0);
    step("f4_p14", 0, 64'd0, 0, 1, 64'd14, 0);
    step("f4_p15", 0, 64'd0, 0, 1, 64'd15, 0);
    step("f4_p16", 0, 64'd0, 0, 1, 64'd16, 1);
    step("f4_end", 0, 64'd0, 0, 0, 64'd0, 0);
    chk("f4_pkt", 64'(pkt_count), 64'd4);
    chk("f4_drop", 64'(drop_count), 64'd2);

    // Frame 5 abandoned by a mid-payload reset
    step("f5_w1", 1, 64'h20, 0, 0, 64'd0, 0);
    step("f5_w2", 1, 64'h21, 0, 0, 64'd0, 0);
    step("f5_w3", 1, 64'h22, 0, 0, 64'd0, 0);
    step("f5_w4", 1, 64'h23, 0, 0, 64'd0, 0);
    step("f5_idle", 0, 64'd0, 0, 0, 64'd0, 0);
    step("f5_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0004_0004, 0);
    step("f5_p1", 0, 64'd0, 0, 1, 64'h20, 0);
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(tx_if.tx_valid), 64'd0);
    chk("ar_data", tx_if.tx_data, 64'd0);
    chk("ar_eof", 64'(tx_if.tx_end_of_frame), 64'd0);
    chk("ar_pkt", 64'(pkt_count), 64'd0);
    chk("ar_drop", 64'(drop_count), 64'd0);
    chk("ar_ip", 64'(tx_if.tx_dest_ip), 64'd0);
    $display("async reset mid-payload -> valid=%0d data=%h pkt=%0d",
             tx_if.tx_valid, tx_if.tx_data, pkt_count);
    @(negedge clk);
    rst = 1'b1;

    // Frame after reset: sequence restarts at 0
    step("f6_w1", 1, 64'h30, 0, 0, 64'd0, 0);
    step("f6_w2", 1, 64'h31, 0, 0, 64'd0, 0);
    step("f6_w3", 1, 64'h32, 0, 0, 64'd0, 0);
    step("f6_w4", 1, 64'h33, 0, 0, 64'd0, 0);
    step("f6_idle", 0, 64'd0, 0, 0, 64'd0, 0);
    step("f6_hdr", 0, 64'd0, 0, 1, 64'h0000_0000_0000_0004, 0);
    chk("f6_ip", 64'(tx_if.tx_dest_ip), 64'h0A00_0002);
    step("f6_p1", 0, 64'd0, 0, 1, 64'h30, 0);
    step("f6_p2", 0, 64'd0, 0, 1, 64'h31, 0);
    step("f6_p3", 0, 64'd0, 0, 1, 64'h32, 0);
    step("f6_p4", 0, 64'd0, 0, 1, 64'h33, 1);
    step("f6_end", 0, 64'd0, 0, 0, 64'd0, 0);
    chk("f6_pkt", 64'(pkt_count), 64'd1);

    // Sticky overflow flag
    chk("ovf_pre", 64'(overflow_seen), 64'd0);
    @(negedge clk);
    tx_if.tx_overflow = 1'b1;
    #1;
    chk("ovf_pulse", 64'(overflow_seen), 64'd0);
    @(negedge clk);
    tx_if.tx_overflow = 1'b0;
    #1;
    chk("ovf_set", 64'(overflow_seen), 64'd1);
    $display("overflow pulse -> overflow_seen=%0d", overflow_seen);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ovf_hold", 64'(overflow_seen), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tge_tx_packetizer.md
Name: tge_tx_packetizer

Overview:
- Upstream feeder for the 10GbE core's fabric TX interface.
- Buffers a 64-bit sample stream from the voltmeter datapath in an internal show-ahead FIFO.
- Frames the data into fixed-length UDP payloads: one header word, then PAYLOAD_WORDS data words.
- Drives tx_valid / tx_data / tx_end_of_frame / tx_dest_ip / tx_dest_port and honours tx_afull backpressure.

Parameters:
- PAYLOAD_WORDS, 128: data words per frame, excluding the header; legal range 1..(2**FIFO_AW - 1).
- FIFO_AW, 9: FIFO address width; depth is 2**FIFO_AW words.

Ports:
- clk  in  1  fabric clock; same clock as the 10GbE core clk.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  enable for accepting input and starting new frames.
- din  in  64  sample word.
- din_valid  in  1  din qualifier.
- dest_ip  in  32  destination IP; sampled at frame start.
- dest_port  in  16  destination UDP port; sampled at frame start.
- tx_afull  in  1  core TX FIFO almost-full.
- tx_overflow  in  1  core TX overflow indication.
- tx_valid  out  1  word valid to the core.
- tx_data  out  64  word to the core.
- tx_end_of_frame  out  1  last word of the frame.
- tx_dest_ip  out  32  latched destination IP.
- tx_dest_port  out  16  latched destination port.
- pkt_count  out  32  frames completed; wraps.
- drop_count  out  32  input words discarded; saturates at 32'hFFFFFFFF.
- overflow_seen  out  1  sticky; set on any tx_overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs, counters, sequence number and FIFO pointers go to 0.
  - FSM goes to IDLE.
  - Asserting reset mid-frame abandons the frame; no EOF is emitted.
- Input side, evaluated each clk:
  - Write to FIFO when din_valid=1 && en=1 && fill < 2**FIFO_AW.
  - If din_valid=1 && en=1 && FIFO full, the word is dropped and drop_count increments (saturating).
  - din_valid while en=0 is ignored and not counted.
- fill is a (FIFO_AW+1)-bit occupancy. A simultaneous write and read leaves fill unchanged.
- FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE -> HEADER when en=1 && fill >= PAYLOAD_WORDS && tx_afull=0. On this transition, latch dest_ip and dest_port into tx_dest_ip and tx_dest_port.
  - HEADER:
    - Drive tx_valid=1, tx_data = {seq[47:0], PAYLOAD_WORDS[15:0]}, tx_end_of_frame=0.
    - Go to PAYLOAD the next cycle. HEADER is a single cycle because tx_afull was already checked on entry.
  - PAYLOAD, on each cycle with tx_afull=0:
    - Pop one FIFO word.
    - tx_data = FIFO head (show-ahead, zero-latency), tx_valid=1.
    - Increment word counter wcnt.
  - PAYLOAD, on a cycle with tx_afull=1: tx_valid=0, no pop, wcnt holds.
  - Final payload word (wcnt = PAYLOAD_WORDS-1, tx_afull=0):
    - tx_end_of_frame=1.
    - seq increments, pkt_count increments.
    - Return to IDLE.
- Once HEADER is entered, the frame always completes. Deasserting en mid-frame does not truncate it. Underflow cannot occur, because a frame starts only with a full payload already buffered.
- Outputs are combinational from FSM state and FIFO head; tx_data is don't-care when tx_valid=0 but is driven 0.
- Minimum spacing: one IDLE cycle between frames. Back-to-back frame rate = PAYLOAD_WORDS+2 cycles.
- tx_dest_ip and tx_dest_port hold their latched values between frames. A dest_ip change mid-frame has no effect until the next frame start.
- overflow_seen: set when tx_overflow=1; cleared only by reset.
- Wrap rules:
  - seq is 48 bits and wraps to 0.
  - pkt_count wraps.
  - drop_count saturates.

Test Plan:
- PAYLOAD_WORDS=4, FIFO_AW=3, en=1; write din=1..4 on consecutive cycles, tx_afull=0 -> tx_valid sequence is header 0x0000000000000004, then 1, 2, 3, 4; tx_end_of_frame high only with word 4; pkt_count=1.
- Same configuration, second frame with din=5..8 -> header 0x0000000000010004; at least one idle cycle between the two frames.
- tx_afull high for 3 cycles after the 2nd payload word -> tx_valid=0 for those 3 cycles; words resume in order with no loss or duplication; EOF still on the 4th word.
- FIFO_AW=3, tx_afull held 1, write 10 words -> fill=8, drop_count=2, tx_valid stays 0; release tx_afull -> two frames of 4 words emitted.
- dest_ip=0x0A000001 at frame start, changed to 0x0A000002 during the payload -> tx_dest_ip stays 0x0A000001 until the next header.
- Two cases:
  - rst pulsed low mid-PAYLOAD -> all outputs 0 immediately (asynchronously); after release, the next frame header carries seq=0.
  - tx_overflow one-cycle pulse -> overflow_seen=1 and stays 1.
